// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: shared types and helpers for audio_mix_scheduler.
//   mix_state_t  - sequencer states (IDLE, SUM_L, SUM_R, PRESENT)
//   SAMPLE_W     - audio sample width
//   SAT_MAX/MIN  - 16-bit signed saturation bounds
//   sat17to16    - clamps a 17-bit signed sum to 16 bits
package audio_mix_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {IDLE, SUM_L, SUM_R, PRESENT} mix_state_t;

  // Overflow iff the two top bits of the 17-bit sum disagree; the top bit
  // then gives the direction of the overflow.
  function automatic logic signed [SAMPLE_W-1:0] sat17to16(input logic signed [SAMPLE_W:0] s);
    if (s[SAMPLE_W] != s[SAMPLE_W-1]) return s[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    return s[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/audio_tick_gen.sv
// audio_tick_gen: free-running divider emitting a one-cycle tick each DIV
// cycles. Counter runs 0..DIV-1; tick_o is high for the cycle in which the
// counter has just wrapped to 0, so the first tick appears DIV cycles after
// reset release.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   tick_o - one-cycle sample-rate strobe
module audio_tick_gen #(
  parameter int DIV = 1042
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;
  logic          tick_q;

  assign wrap  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end

  assign tick_o = tick_q;
endmodule

// File: rtl/audio_mix_scheduler.sv
// audio_mix_scheduler: mixes core stereo audio with decoded MIDI stereo audio
// at the output sample rate, using one shared saturating adder sequenced L
// then R, and presents the pair to the I2S transmitter with valid/ready.
//   clk, reset              - clock50 domain, async active-high reset
//   core_l/r                - level-held core samples (signed)
//   midi_l/r, midi_valid    - decoded MIDI samples with one-cycle strobe
//   core_atten, midi_atten  - per-source arithmetic right shift 0..3
//   out_l/r, out_valid, out_ready - mixed sample handshake
//   overrun_cnt             - saturating count of dropped ticks
//   midi_active             - MIDI still inside its timeout window
//   peak_l/r, peak_clr      - peak meter, built only with AUDIO_MIX_PEAK_METER_EN
module audio_mix_scheduler
  import audio_mix_pkg::*;
#(
  parameter int CLKMHZ       = 50,
  parameter int FS_HZ        = 48000,
  parameter int MIDI_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] core_l,
  input  logic [15:0] core_r,
  input  logic [15:0] midi_l,
  input  logic [15:0] midi_r,
  input  logic        midi_valid,
  input  logic [1:0]  core_atten,
  input  logic [1:0]  midi_atten,
  input  logic        out_ready,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  output logic [7:0]  overrun_cnt,
  output logic        midi_active,
  output logic [14:0] peak_l,
  output logic [14:0] peak_r,
  input  logic        peak_clr
);
  localparam int DIV = (CLKMHZ * 1000000 + FS_HZ / 2) / FS_HZ;
  localparam int TW  = $clog2(MIDI_TIMEOUT + 1);

  logic tick;
  audio_tick_gen #(.DIV(DIV)) u_tick (.clk_i(clk), .rst_i(reset), .tick_o(tick));

  // ---------------- MIDI hold + timeout ----------------
  logic signed [15:0] mhold_l_q, mhold_r_q;
  logic [TW-1:0]      mto_q;
  logic               midi_live;
  logic signed [15:0] mcur_l, mcur_r;

  // A strobe coinciding with a tick must be seen by that tick, so the
  // snapshot path bypasses the hold registers.
  always_comb begin
    midi_live = midi_valid || (mto_q != '0);
    mcur_l    = '0;
    mcur_r    = '0;
    if (midi_live) begin
      mcur_l = midi_valid ? midi_l : mhold_l_q;
      mcur_r = midi_valid ? midi_r : mhold_r_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mhold_l_q <= '0;
      mhold_r_q <= '0;
      mto_q     <= '0;
    end else if (midi_valid) begin
      mhold_l_q <= midi_l;
      mhold_r_q <= midi_r;
      mto_q     <= TW'(MIDI_TIMEOUT);
    end else if (tick && mto_q != '0) begin
      mto_q <= mto_q - 1'b1;
    end
  end

  assign midi_active = (mto_q != '0);

  // ---------------- Sequencer ----------------
  mix_state_t         state_q, state_d;
  logic signed [15:0] snap_cl_q, snap_cl_d, snap_cr_q, snap_cr_d;
  logic signed [15:0] snap_ml_q, snap_ml_d, snap_mr_q, snap_mr_d;
  logic [1:0]         ca_q, ca_d, ma_q, ma_d;
  logic signed [15:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic               valid_q, valid_d;
  logic [7:0]         ovr_q, ovr_d;

  // Shared adder: operands selected by which SUM state is active.
  logic signed [15:0] sel_c, sel_m, sh_c, sh_m, sat;
  logic signed [16:0] sum;
  always_comb begin
    sel_c = (state_q == SUM_R) ? snap_cr_q : snap_cl_q;
    sel_m = (state_q == SUM_R) ? snap_mr_q : snap_ml_q;
    sh_c  = sel_c >>> ca_q;
    sh_m  = sel_m >>> ma_q;
    sum   = {sh_c[15], sh_c} + {sh_m[15], sh_m};
    sat   = sat17to16(sum);
  end

  always_comb begin
    state_d   = state_q;
    snap_cl_d = snap_cl_q;
    snap_cr_d = snap_cr_q;
    snap_ml_d = snap_ml_q;
    snap_mr_d = snap_mr_q;
    ca_d      = ca_q;
    ma_d      = ma_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    if (tick && state_q != IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    case (state_q)
      IDLE: if (tick) begin
        snap_cl_d = core_l;
        snap_cr_d = core_r;
        snap_ml_d = mcur_l;
        snap_mr_d = mcur_r;
        ca_d      = core_atten;
        ma_d      = midi_atten;
        state_d   = SUM_L;
      end
      SUM_L: begin
        out_l_d = sat;
        state_d = SUM_R;
      end
      SUM_R: begin
        out_r_d = sat;
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: if (valid_q && out_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_cl_q <= '0;
      snap_cr_q <= '0;
      snap_ml_q <= '0;
      snap_mr_q <= '0;
      ca_q      <= '0;
      ma_q      <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      snap_cl_q <= snap_cl_d;
      snap_cr_q <= snap_cr_d;
      snap_ml_q <= snap_ml_d;
      snap_mr_q <= snap_mr_d;
      ca_q      <= ca_d;
      ma_q      <= ma_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_l       = out_l_q;
  assign out_r       = out_r_q;
  assign out_valid   = valid_q;
  assign overrun_cnt = ovr_q;

  // ---------------- Optional peak meter ----------------
`ifdef AUDIO_MIX_PEAK_METER_EN
  logic [14:0] peak_l_q, peak_r_q, mag;

  // |SAT_MIN| does not fit in 15 bits, so it clamps to the largest magnitude.
  always_comb begin
    if (!sat[15])          mag = sat[14:0];
    else if (sat == SAT_MIN) mag = 15'h7FFF;
    else                   mag = 15'(-sat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else if (peak_clr) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      if (state_q == SUM_L && mag > peak_l_q) peak_l_q <= mag;
      if (state_q == SUM_R && mag > peak_r_q) peak_r_q <= mag;
    end
  end

  assign peak_l = peak_l_q;
  assign peak_r = peak_r_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_l = '0;
  assign peak_r = '0;
`endif
endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Self-checking bench for audio_mix_scheduler. A cycle-level reference model
// built from the sample-rate / timeout / handshake rules pushes expected
// sample pairs into a queue; an independent monitor pops and compares on
// each accepted output. Honours AUDIO_MIX_PEAK_METER_EN for the peak meter.
module tb_audio_mix_scheduler;
  localparam int CLKMHZ       = 1;
  localparam int FS_HZ        = 40000;
  localparam int MIDI_TIMEOUT = 16;
  localparam int DIV          = (CLKMHZ * 1000000 + FS_HZ / 2) / FS_HZ;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] core_l = '0, core_r = '0, midi_l = '0, midi_r = '0;
  logic        midi_valid = 1'b0;
  logic [1:0]  core_atten = '0, midi_atten = '0;
  logic        out_ready = 1'b1;
  logic        peak_clr = 1'b0;
  logic [15:0] out_l, out_r;
  logic        out_valid, midi_active;
  logic [7:0]  overrun_cnt;
  logic [14:0] peak_l, peak_r;

  always #5 clk = ~clk;

  audio_mix_scheduler #(.CLKMHZ(CLKMHZ), .FS_HZ(FS_HZ), .MIDI_TIMEOUT(MIDI_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .core_l(core_l), .core_r(core_r),
    .midi_l(midi_l), .midi_r(midi_r), .midi_valid(midi_valid),
    .core_atten(core_atten), .midi_atten(midi_atten), .out_ready(out_ready),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
    .overrun_cnt(overrun_cnt), .midi_active(midi_active),
    .peak_l(peak_l), .peak_r(peak_r), .peak_clr(peak_clr));

  typedef struct { int l; int r; int vcyc; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // model state
  int cyc = 0, mcnt = 0, mhl = 0, mhr = 0, ovr = 0, acc_from = 0;
  int pk_l = 0, pk_r = 0;
  bit busy = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int mix(input int c, input int ca, input int m, input int ma);
    int s;
    s = (c >>> ca) + (m >>> ma);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic int mag(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 32767) ? 32767 : a;
  endfunction

  // Reference model: posedge number cyc after reset release. The divider's
  // tick is acted on at edges DIV+1, 2*DIV+1, ...
  always @(posedge clk) begin
    if (reset) begin
      cyc = 0; mcnt = 0; mhl = 0; mhr = 0; ovr = 0; busy = 0;
      pk_l = 0; pk_r = 0;
      q.delete();
    end else begin
      bit tk, live;
      int ml, mr;
      exp_t e;
      cyc++;
      tk   = (cyc > 1) && ((cyc - 1) % DIV == 0);
      live = midi_valid || (mcnt != 0);
      ml   = !live ? 0 : (midi_valid ? int'($signed(midi_l)) : mhl);
      mr   = !live ? 0 : (midi_valid ? int'($signed(midi_r)) : mhr);
      if (tk) begin
        if (busy) begin
          if (ovr < 255) ovr++;
        end else begin
          e.l = mix($signed(core_l), core_atten, ml, midi_atten);
          e.r = mix($signed(core_r), core_atten, mr, midi_atten);
          e.vcyc = cyc + 2;
          q.push_back(e);
          busy = 1;
          acc_from = cyc + 3;
`ifdef AUDIO_MIX_PEAK_METER_EN
          if (mag(e.l) > pk_l) pk_l = mag(e.l);
          if (mag(e.r) > pk_r) pk_r = mag(e.r);
`endif
        end
      end
      if (busy && cyc >= acc_from && out_ready) busy = 0;
      if (midi_valid) begin
        mhl = $signed(midi_l); mhr = $signed(midi_r); mcnt = MIDI_TIMEOUT;
      end else if (tk && mcnt > 0) mcnt--;
`ifdef AUDIO_MIX_PEAK_METER_EN
      if (peak_clr) begin pk_l = 0; pk_r = 0; end
`endif
    end
  end

  // Monitor: compares on each accepted sample, plus valid-rise latency.
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (reset) prev_valid = 0;
    else begin
      if (out_valid && !prev_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: out_valid high with nothing expected at cycle %0d", cyc);
        end else chk("valid_latency", cyc, q[0].vcyc);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out_l", int'($signed(out_l)), e.l);
        chk("out_r", int'($signed(out_r)), e.r);
        chk("overrun_cnt", int'(overrun_cnt), ovr);
        chk("midi_active", int'(midi_active), int'(mcnt != 0));
        chk("peak_l", int'(peak_l), pk_l);
        chk("peak_r", int'(peak_r), pk_r);
      end
      prev_valid = out_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: out_valid not seen within %0d cycles", nm, bound);
    end
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    midi_l = l; midi_r = r; midi_valid = 1'b1;
    step(1);
    midi_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [15:0] hold_l, hold_r;
    core_l = 16'h1000; core_r = 16'h0200;
    step(3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_l", int'(out_l), 0);
    chk("rst_overrun", int'(overrun_cnt), 0);
    chk("rst_midi_active", int'(midi_active), 0);
    chk("rst_peak_l", int'(peak_l), 0);
    reset = 1'b0;

    // first tick: valid 3 cycles after the tick at cycle DIV
    wait_valid("first_valid", DIV + 10, ok);
    if (ok) begin
      chk("first_latency", cyc, DIV + 3);
      chk("first_out_l", int'(out_l), 16'h1000);
    end

    // saturation both ways
    step(1);
    core_l = 16'h7000; core_r = 16'h8000;
    strobe(16'h7000, 16'h8000);
    step(2 * DIV);
    chk("sat_pos", int'(out_l), 16'h7FFF);
    chk("sat_neg", int'(out_r), 16'h8000);

    // MIDI timeout: 16 ticks with MIDI, then silent
    core_l = 16'h0100; core_r = 16'h0000;
    strobe(16'h0100, 16'h0000);
    step(20 * DIV);
    chk("timeout_out_l", int'(out_l), 16'h0100);
    chk("timeout_inactive", int'(midi_active), 0);

    // attenuation keeps sign
    core_atten = 2'd2; core_l = 16'h8000;
    step(2 * DIV);
    chk("atten_neg", int'(out_l), 16'hE000);
    core_atten = 2'd0;

    // backpressure across three ticks
    out_ready = 1'b0;
    wait_valid("bp_valid", 2 * DIV, ok);
    hold_l = out_l; hold_r = out_r;
    core_l = 16'h1234; core_r = 16'h4321;
    step(2 * DIV);
    chk("bp_stable_l", int'(out_l), int'(hold_l));
    chk("bp_stable_r", int'(out_r), int'(hold_r));
    chk("bp_valid_held", int'(out_valid), 1);
    chk("bp_overrun", int'(overrun_cnt), 2);
    out_ready = 1'b1;
    step(2);
    chk("bp_released", int'(out_valid), 0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      core_l = 16'($urandom); core_r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        core_atten = 2'($urandom); midi_atten = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) strobe(16'($urandom), 16'($urandom));
      step($urandom_range(1, DIV / 2));
    end

    // overrun saturation
    out_ready = 1'b0;
    step(262 * DIV);
    chk("ovr_saturate", int'(overrun_cnt), 255);
    out_ready = 1'b1;
    step(DIV);

    // reset in flight aborts at once
    out_ready = 1'b0;
    wait_valid("abort_valid", 2 * DIV, ok);
    #1 reset = 1'b1;
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_overrun", int'(overrun_cnt), 0);
    chk("abort_out_l", int'(out_l), 0);
    step(2);
    out_ready = 1'b1;
    reset = 1'b0;

`ifdef AUDIO_MIX_PEAK_METER_EN
    core_atten = 2'd0; midi_atten = 2'd0;
    core_l = 16'h8000; core_r = 16'h0000;
    step(DIV + 5);
    chk("peak_minclamp", int'(peak_l), 32767);
    peak_clr = 1'b1;
    step(1);
    peak_clr = 1'b0;
    chk("peak_clear", int'(peak_l), 0);
    core_l = 16'h0040;
    step(DIV + 5);
    chk("peak_after_clr", int'(peak_l), 64);
`else
    step(DIV + 5);
    chk("peak_tied_l", int'(peak_l), 0);
    chk("peak_tied_r", int'(peak_r), 0);
`endif

    for (int i = 0; i < 60; i++) begin
      core_l = 16'($urandom); core_r = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) strobe(16'($urandom), 16'($urandom));
      step($urandom_range(1, DIV));
    end
    out_ready = 1'b1;
    step(DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_mix_scheduler.md
Name: audio_mix_scheduler

Overview:
- Combines the core's stereo audio and the decoded MIDI/I2S-in stereo audio into one sample stream for the I2S transmitter.
- Generates the output sample-rate tick and captures both sources on that tick.
- Applies per-source attenuation, then does a saturating sum through one shared adder, sequenced over L then R.
- Sits between the Spectrum core / i2s_decoder outputs and the i2s_sound input, in the clock50 domain.

Parameters:
- CLKMHZ, 50, system clock in MHz.
- FS_HZ, 48000, output sample rate. Derived divider DIV = (CLKMHZ*1000000 + FS_HZ/2) / FS_HZ, which is 1042 at the defaults.
- MIDI_TIMEOUT, 16, number of ticks without midi_valid before the MIDI source is treated as silent.

Ports:
- clk  in  1  system clock (clock50)
- reset  in  1  asynchronous, active-high reset
- core_l  in  16  core left sample, signed, level-held
- core_r  in  16  core right sample, signed, level-held
- midi_l  in  16  decoded MIDI left sample, signed
- midi_r  in  16  decoded MIDI right sample, signed
- midi_valid  in  1  one-cycle strobe; midi_l/midi_r are valid in this cycle
- core_atten  in  2  arithmetic right shift applied to the core source, 0..3
- midi_atten  in  2  arithmetic right shift applied to the MIDI source, 0..3
- out_ready  in  1  downstream accepts the sample when out_valid && out_ready
- out_l  out  16  mixed left sample, signed
- out_r  out  16  mixed right sample, signed
- out_valid  out  1  mixed sample pair is available
- overrun_cnt  out  8  saturating count of dropped ticks
- midi_active  out  1  MIDI source is currently inside its timeout window
- peak_l  out  15  left peak magnitude (optional feature)
- peak_r  out  15  right peak magnitude (optional feature)
- peak_clr  in  1  clear the peak registers (optional feature)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; tick counter 0; MIDI hold registers 0; timeout counter 0.
- Tick generator: counts 0..DIV-1 and pulses tick for one cycle when it wraps to 0. The first tick occurs DIV cycles after reset is released.
- MIDI capture: on midi_valid, midi_l/midi_r are latched into the hold registers and the timeout counter reloads to MIDI_TIMEOUT. Each tick with no midi_valid in the same cycle decrements the counter, stopping at 0.
  - midi_active = (counter != 0).
  - When midi_active = 0, the MIDI contribution is 0.
  - midi_valid in the same cycle as a tick: the new MIDI value is the one used by that tick.
- FSM states: IDLE, SUM_L, SUM_R, PRESENT.
  - IDLE: on tick, latch core_l/core_r and the atten inputs into snapshot registers; go to SUM_L.
  - SUM_L: shared adder computes (core_l >>> ca) + (midi_l >>> ma) at 17-bit width. Saturate to [-32768, 32767]; write to out_l. Go to SUM_R.
  - SUM_R: same computation for the right channel into out_r. Set out_valid = 1; go to PRESENT.
  - PRESENT: hold out_l, out_r and out_valid stable. On out_valid && out_ready, clear out_valid and return to IDLE in the same edge.
- Latency: tick at cycle t → out_valid = 1 at cycle t+3.
  - If out_ready is high at t+3, the sample is accepted at t+3; the FSM is back in IDLE from t+4.
- Overrun: a tick that arrives while the FSM is not in IDLE is dropped. overrun_cnt increments and saturates at 255. The sample already in flight is not disturbed.
- The attenuation inputs take effect at the next tick, never mid-sample.
- Asynchronous reset in any state aborts the operation immediately and deasserts out_valid.

Optional Feature:
- Macro AUDIO_MIX_PEAK_METER_EN.
- Defined:
  - After each SUM state, peak_x updates to max(peak_x, |out_x|), where |-32768| is clamped to 32767 (15-bit magnitude).
  - peak_clr zeroes both peak registers. If peak_clr coincides with an update, the clear wins.
  - Peak registers reset to 0.
- Undefined: peak_l/peak_r are tied to 0, peak_clr is ignored, and no peak registers are inferred.

Decomposition:
- Package audio_mix_pkg:
  - mix_state_t enum for the FSM states.
  - SAMPLE_W = 16.
  - SAT_MAX / SAT_MIN constants.
  - sat17to16 function.
- One natural sub-module, audio_tick_gen: the parameterised divider that emits a one-cycle tick. It can be reused by i2s_sound.

Test Plan:
- Reset, then wait DIV cycles: first tick fires; out_valid rises exactly 3 cycles later. With core_l = 0x1000, midi silent and out_ready = 1, out_l = 0x1000.
- core_l = 0x7000, midi_l = 0x7000 strobed, atten 0 → out_l = 0x7FFF. core_r = 0x8000, midi_r = 0x8000 → out_r = 0x8000. Both saturate.
- core_atten = 2, core_l = 0x8000, midi silent → out_l = 0xE000 (arithmetic shift preserves sign).
- One midi_valid with midi_l = 0x0100, then no further strobes: MIDI is included for 16 ticks; from tick 17 onward it contributes 0 and midi_active = 0.
- Hold out_ready = 0 across 3 ticks: out_l/out_r stay stable and overrun_cnt = 2. Raise out_ready: the sample is accepted and the FSM returns to IDLE.
- With AUDIO_MIX_PEAK_METER_EN defined: a sample of -32768 gives peak_l = 32767. Pulse peak_clr → 0; the next sample 0x0040 gives peak_l = 64.
